// File: rtl/code_entry_controller.sv
// Digital lock sequencer: assembles button-edge digits into a fixed-length code, checks it,
// and holds unlock/error status for timed periods. Optional lockout via CODE_ENTRY_LOCKOUT_EN.
module code_entry_controller #(
    parameter int unsigned NUM_BUTTONS    = 4,
    parameter int unsigned CODE_LENGTH    = 4,
    parameter int unsigned ENTRY_TIMEOUT  = 50000000,
    parameter int unsigned UNLOCK_CYCLES  = 250000000,
    parameter int unsigned ERROR_CYCLES   = 100000000,
    parameter int unsigned MAX_ATTEMPTS   = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1500000000
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic [NUM_BUTTONS-1:0]                       buttonEdge,
    input  logic [CODE_LENGTH*$clog2(NUM_BUTTONS)-1:0]   storedCode,
    output logic                                         unlocked,
    output logic                                         error,
    output logic                                         lockedOut,
    output logic [$clog2(CODE_LENGTH+1)-1:0]             digitCount,
    output logic [2:0]                                   state
);

    localparam int unsigned DW     = $clog2(NUM_BUTTONS);
    localparam int unsigned CW     = $clog2(CODE_LENGTH + 1);
    localparam int unsigned HOLD_A = (ENTRY_TIMEOUT > UNLOCK_CYCLES) ? ENTRY_TIMEOUT : UNLOCK_CYCLES;
    localparam int unsigned HOLD_B = (HOLD_A > ERROR_CYCLES) ? HOLD_A : ERROR_CYCLES;
`ifdef CODE_ENTRY_LOCKOUT_EN
    localparam int unsigned HOLD_MAX = (HOLD_B > LOCKOUT_CYCLES) ? HOLD_B : LOCKOUT_CYCLES;
    localparam int unsigned FW_RAW   = $clog2(MAX_ATTEMPTS + 1);
    localparam int unsigned FW       = (FW_RAW > 2) ? FW_RAW : 2;
`else
    localparam int unsigned HOLD_MAX = HOLD_B;
`endif
    localparam int unsigned TW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;

    // Reject degenerate configurations at elaboration.
    if (NUM_BUTTONS < 2 || CODE_LENGTH < 1 || ENTRY_TIMEOUT < 1 || UNLOCK_CYCLES < 1 ||
        ERROR_CYCLES < 1 || MAX_ATTEMPTS < 1 || LOCKOUT_CYCLES < 1) begin : g_param_check
        $error("code_entry_controller: invalid parameter value");
    end

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ENTRY      = 3'd1,
        CHECK      = 3'd2,
        UNLOCKED   = 3'd3,
        ERROR_HOLD = 3'd4,
        LOCKOUT    = 3'd5
    } state_e;

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [CW-1:0] count_q, count_d;
    logic          mismatch_q, mismatch_d;
    logic          unlocked_q, error_q;
`ifdef CODE_ENTRY_LOCKOUT_EN
    logic [FW-1:0] fail_q, fail_d;
    logic          locked_q;
`endif

    logic          edge_any;
    logic          edge_multi;
    logic [DW-1:0] edge_digit;
    logic [DW-1:0] stored_digit;
    logic          digit_bad;

    // Edge decode and comparison against the stored digit at the current position.
    always_comb begin
        edge_any     = |buttonEdge;
        edge_multi   = edge_any && !$onehot(buttonEdge);
        edge_digit   = '0;
        for (int i = 0; i < NUM_BUTTONS; i++) begin
            if (buttonEdge[i]) edge_digit = DW'(i);
        end
        stored_digit = DW'(storedCode >> (32'(count_q) * DW));
        digit_bad    = edge_multi || (edge_digit != stored_digit);
    end

    // Next-state logic; the shared timer is cleared on every transition.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        count_d    = count_q;
        mismatch_d = mismatch_q;
`ifdef CODE_ENTRY_LOCKOUT_EN
        fail_d     = fail_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (edge_any) begin
                    mismatch_d = digit_bad;
                    count_d    = CW'(1);
                    state_d    = (CODE_LENGTH == 1) ? CHECK : ENTRY;
                end
            end
            ENTRY: begin
                if (edge_any) begin
                    mismatch_d = mismatch_q | digit_bad;
                    count_d    = count_q + CW'(1);
                    timer_d    = '0;
                    if (count_q == CW'(CODE_LENGTH - 1)) state_d = CHECK;
                end else if (timer_q == TW'(ENTRY_TIMEOUT - 1)) begin
                    state_d    = IDLE;
                    count_d    = '0;
                    mismatch_d = 1'b0;
                    timer_d    = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            CHECK: begin
                count_d    = '0;
                timer_d    = '0;
                mismatch_d = 1'b0;
                if (mismatch_q) begin
                    state_d = ERROR_HOLD;
`ifdef CODE_ENTRY_LOCKOUT_EN
                    fail_d  = fail_q + FW'(1);
`endif
                end else begin
                    state_d = UNLOCKED;
`ifdef CODE_ENTRY_LOCKOUT_EN
                    fail_d  = '0;
`endif
                end
            end
            UNLOCKED: begin
                // A relocking press is consumed here and never becomes digit 0.
                if (edge_any || timer_q == TW'(UNLOCK_CYCLES - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            ERROR_HOLD: begin
                if (timer_q == TW'(ERROR_CYCLES - 1)) begin
                    timer_d = '0;
`ifdef CODE_ENTRY_LOCKOUT_EN
                    state_d = (fail_q >= FW'(MAX_ATTEMPTS)) ? LOCKOUT : IDLE;
`else
                    state_d = IDLE;
`endif
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`ifdef CODE_ENTRY_LOCKOUT_EN
            LOCKOUT: begin
                if (timer_q == TW'(LOCKOUT_CYCLES - 1)) begin
                    state_d = IDLE;
                    timer_d = '0;
                    fail_d  = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
`endif
            default: begin
                state_d    = IDLE;
                timer_d    = '0;
                count_d    = '0;
                mismatch_d = 1'b0;
            end
        endcase
    end

    // State, datapath and registered status outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            count_q    <= '0;
            mismatch_q <= 1'b0;
            unlocked_q <= 1'b0;
            error_q    <= 1'b0;
`ifdef CODE_ENTRY_LOCKOUT_EN
            fail_q     <= '0;
            locked_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            count_q    <= count_d;
            mismatch_q <= mismatch_d;
            unlocked_q <= (state_d == UNLOCKED);
            error_q    <= (state_d == ERROR_HOLD);
`ifdef CODE_ENTRY_LOCKOUT_EN
            fail_q     <= fail_d;
            locked_q   <= (state_d == LOCKOUT);
`endif
        end
    end

    assign unlocked   = unlocked_q;
    assign error      = error_q;
    assign digitCount = count_q;
    assign state      = state_q;
`ifdef CODE_ENTRY_LOCKOUT_EN
    assign lockedOut  = locked_q;
`else
    assign lockedOut  = 1'b0;
`endif

endmodule
